cpu_ctrl_seq: RTL and testbench

- Hardwired control sequencer for the mini CPU bus datapath.
- Generates one control step per clock: fetch, decode, then a per-class execute sequence.
- Drives the existing datapath strobes, register-select lines (consumed by select/encode logic) and the 5-bit ALU op.
- Handshakes with memory through Read/Write and mem_rdy; halts on HALT opcode or memory timeout.

---
 rtl/cpu_ctrl_pkg.sv | 44 ++++
 rtl/ctrl_decode.sv | 25 ++
 rtl/cpu_ctrl_seq.sv | 185 ++++++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the mini-CPU control sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_RTYPE, CL_LD, CL_ST, CL_ADDI, CL_NOP, CL_HALT, CL_ILL
  } iclass_t;

  localparam logic [4:0] OP_LD   = 5'b10000;
  localparam logic [4:0] OP_ST   = 5'b10001;
  localparam logic [4:0] OP_ADDI = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b10011;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef struct packed {
    logic       pc_out;
    logic       zlow_out;
    logic       mdr_out;
    logic       c_out;
    logic       ba_out;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       mar_in;
    logic       pc_in;
    logic       mdr_in;
    logic       ir_in;
    logic       y_in;
    logic       in_pc;
    logic       zhigh_in;
    logic       zlow_in;
    logic       read;
    logic       write;
    logic [4:0] op;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode to instruction-class decode; purely combinational.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opc,
  output iclass_t    cls
);

  always_comb begin
    cls = CL_ILL;
    if (!opc[4]) begin
      cls = CL_RTYPE;
    end else begin
      case (opc)
        OP_LD:   cls = CL_LD;
        OP_ST:   cls = CL_ST;
        OP_ADDI: cls = CL_ADDI;
        OP_NOP:  cls = CL_NOP;
        OP_HALT: cls = CL_HALT;
        default: cls = CL_ILL;
      endcase
    end
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Hardwired fetch/decode/execute sequencer; outputs are registered decodes of
// the next state so every strobe comes straight from a flop.
module cpu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW    = 5,
  parameter int MEM_TO = 16
) (
  input  logic           Clock,
  input  logic           clear,
  input  logic [31:0]    IR,
  input  logic           mem_rdy,
  output logic           PCout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           Cout,
  output logic           BAout,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           MARin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           InPC,
  output logic           ZHighin,
  output logic           Zlowin,
  output logic           Read,
  output logic           Write,
  output logic [OPW-1:0] op,
  output logic           run,
  output logic           fault,
  output logic           illegal
);

  localparam int CW = (MEM_TO > 1) ? $clog2(MEM_TO + 1) : 1;

  state_t        state, state_nxt;
  logic [4:0]    opc, opc_nxt;
  iclass_t       cls;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          is_wait, timeout;
  ctrl_t         ctl, ctl_nxt;

  // Ra/Rb/Rc/C operand fields are consumed by the select/encode logic.
  logic unused_ir;
  assign unused_ir = ^IR[26:0];

  ctrl_decode u_decode (
    .opc (opc_nxt),
    .cls (cls)
  );

  always_comb begin
    opc_nxt = (state == ST_T2) ? IR[31:27] : opc;
    is_wait = (state == ST_T1) || (state == ST_T6 && cls == CL_LD) ||
              (state == ST_T7 && cls == CL_ST);
    timeout = is_wait && !mem_rdy && (MEM_TO > 0) &&
              (({1'b0, cnt} + (CW+1)'(1)) == (CW+1)'(MEM_TO));

    state_nxt = state;
    case (state)
      ST_RST:  state_nxt = ST_T0;
      ST_T0:   state_nxt = ST_T1;
      ST_T1:   if (mem_rdy) state_nxt = ST_T2;
      ST_T2:   state_nxt = ST_T3;
      ST_T3: begin
        case (cls)
          CL_NOP, CL_ILL: state_nxt = ST_T0;
          CL_HALT:        state_nxt = ST_HALT;
          default:        state_nxt = ST_T4;
        endcase
      end
      ST_T4:   state_nxt = ST_T5;
      ST_T5:   state_nxt = (cls == CL_LD || cls == CL_ST) ? ST_T6 : ST_T0;
      ST_T6:   if (cls == CL_ST || mem_rdy) state_nxt = ST_T7;
      ST_T7:   if (cls == CL_LD || mem_rdy) state_nxt = ST_T0;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RST;
    endcase
    if (timeout) state_nxt = ST_HALT;

    // Counter only runs while parked in a wait state; any move clears it.
    cnt_nxt = (is_wait && state_nxt == state) ? cnt + CW'(1) : '0;
  end

  always_comb begin
    ctl_nxt = '0;
    case (state_nxt)
      ST_T0: begin
        ctl_nxt.pc_out = 1'b1; ctl_nxt.mar_in = 1'b1;
        ctl_nxt.in_pc = 1'b1;  ctl_nxt.zlow_in = 1'b1;
      end
      ST_T1: begin
        ctl_nxt.zlow_out = 1'b1; ctl_nxt.pc_in = 1'b1;
        ctl_nxt.read = 1'b1;     ctl_nxt.mdr_in = 1'b1;
      end
      ST_T2: begin
        ctl_nxt.mdr_out = 1'b1; ctl_nxt.ir_in = 1'b1;
      end
      ST_T3: begin
        if (cls == CL_RTYPE || cls == CL_ADDI) begin
          ctl_nxt.grb = 1'b1; ctl_nxt.r_out = 1'b1; ctl_nxt.y_in = 1'b1;
        end else if (cls == CL_LD || cls == CL_ST) begin
          ctl_nxt.grb = 1'b1; ctl_nxt.ba_out = 1'b1; ctl_nxt.y_in = 1'b1;
        end
        ctl_nxt.illegal = (cls == CL_ILL);
      end
      ST_T4: begin
        ctl_nxt.zlow_in = 1'b1;
        if (cls == CL_RTYPE) begin
          ctl_nxt.grc = 1'b1; ctl_nxt.r_out = 1'b1;
          ctl_nxt.zhigh_in = 1'b1; ctl_nxt.op = opc_nxt;
        end else begin
          ctl_nxt.c_out = 1'b1; ctl_nxt.op = ALU_ADD;
        end
      end
      ST_T5: begin
        ctl_nxt.zlow_out = 1'b1;
        if (cls == CL_LD || cls == CL_ST) ctl_nxt.mar_in = 1'b1;
        else begin
          ctl_nxt.gra = 1'b1; ctl_nxt.r_in = 1'b1;
        end
      end
      ST_T6: begin
        ctl_nxt.mdr_in = 1'b1;
        if (cls == CL_LD) ctl_nxt.read = 1'b1;
        else begin
          ctl_nxt.gra = 1'b1; ctl_nxt.r_out = 1'b1;
        end
      end
      ST_T7: begin
        if (cls == CL_LD) begin
          ctl_nxt.mdr_out = 1'b1; ctl_nxt.gra = 1'b1; ctl_nxt.r_in = 1'b1;
        end else ctl_nxt.write = 1'b1;
      end
      default: ctl_nxt = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state <= ST_RST;
      opc   <= '0;
      cnt   <= '0;
      fault <= 1'b0;
      run   <= 1'b0;
      ctl   <= '0;
    end else begin
      state <= state_nxt;
      opc   <= opc_nxt;
      cnt   <= cnt_nxt;
      fault <= fault | timeout;
      run   <= (state_nxt != ST_RST) && (state_nxt != ST_HALT);
      ctl   <= ctl_nxt;
    end
  end

  assign PCout   = ctl.pc_out;
  assign Zlowout = ctl.zlow_out;
  assign MDRout  = ctl.mdr_out;
  assign Cout    = ctl.c_out;
  assign BAout   = ctl.ba_out;
  assign Gra     = ctl.gra;
  assign Grb     = ctl.grb;
  assign Grc     = ctl.grc;
  assign Rin     = ctl.r_in;
  assign Rout    = ctl.r_out;
  assign MARin   = ctl.mar_in;
  assign PCin    = ctl.pc_in;
  assign MDRin   = ctl.mdr_in;
  assign IRin    = ctl.ir_in;
  assign Yin     = ctl.y_in;
  assign InPC    = ctl.in_pc;
  assign ZHighin = ctl.zhigh_in;
  assign Zlowin  = ctl.zlow_in;
  assign Read    = ctl.read;
  assign Write   = ctl.write;
  assign op      = OPW'(ctl.op);
  assign illegal = ctl.illegal;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: directed vector table, hand-written corner sequences,
// then random instructions checked against a microprogram-style reference model.
module tb_cpu_ctrl_seq;

  localparam int MEM_TO = 4;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
  logic        mem_rdy = 1'b0;
  logic [31:0] IR = '0;
  logic PCout, Zlowout, MDRout, Cout, BAout, Gra, Grb, Grc, Rin, Rout;
  logic MARin, PCin, MDRin, IRin, Yin, InPC, ZHighin, Zlowin, Read, Write;
  logic [4:0] op;
  logic run, fault, illegal;

  always #5 Clock = ~Clock;

  cpu_ctrl_seq #(.OPW(5), .MEM_TO(MEM_TO)) dut (
    .Clock(Clock), .clear(clear), .IR(IR), .mem_rdy(mem_rdy),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .BAout(BAout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .InPC(InPC), .ZHighin(ZHighin), .Zlowin(Zlowin), .Read(Read), .Write(Write),
    .op(op), .run(run), .fault(fault), .illegal(illegal)
  );

  typedef struct packed {
    logic PCout, Zlowout, MDRout, Cout, BAout, Gra, Grb, Grc, Rin, Rout;
    logic MARin, PCin, MDRin, IRin, Yin, InPC, ZHighin, Zlowin, Read, Write;
    logic [4:0] op;
    logic run, fault, illegal;
  } vec_t;

  typedef struct packed { logic clr; logic rdy; logic [4:0] o; vec_t exp; } row_t;
  typedef struct packed { vec_t v; logic wt; } step_t;

  vec_t act_v;
  assign act_v = {PCout, Zlowout, MDRout, Cout, BAout, Gra, Grb, Grc, Rin, Rout,
                  MARin, PCin, MDRin, IRin, Yin, InPC, ZHighin, Zlowin, Read, Write,
                  op, run, fault, illegal};

  int checks = 0;
  int errors = 0;

  function automatic vec_t setf(input vec_t r_in, input string t);
    vec_t r = r_in;
    case (t)
      "PCout":   r.PCout = 1'b1;   "Zlowout": r.Zlowout = 1'b1;
      "MDRout":  r.MDRout = 1'b1;  "Cout":    r.Cout = 1'b1;
      "BAout":   r.BAout = 1'b1;   "Gra":     r.Gra = 1'b1;
      "Grb":     r.Grb = 1'b1;     "Grc":     r.Grc = 1'b1;
      "Rin":     r.Rin = 1'b1;     "Rout":    r.Rout = 1'b1;
      "MARin":   r.MARin = 1'b1;   "PCin":    r.PCin = 1'b1;
      "MDRin":   r.MDRin = 1'b1;   "IRin":    r.IRin = 1'b1;
      "Yin":     r.Yin = 1'b1;     "InPC":    r.InPC = 1'b1;
      "ZHighin": r.ZHighin = 1'b1; "Zlowin":  r.Zlowin = 1'b1;
      "Read":    r.Read = 1'b1;    "Write":   r.Write = 1'b1;
      "run":     r.run = 1'b1;     "fault":   r.fault = 1'b1;
      "illegal": r.illegal = 1'b1;
      default: begin
        errors++;
        $display("FAIL token: unknown signal name '%s' in expectation", t);
      end
    endcase
    return r;
  endfunction

  // Builds an expected output vector from a space-separated list of asserted names.
  function automatic vec_t E(input string s, input logic [4:0] o = 5'd0);
    vec_t r = '0;
    int st = 0;
    r.op = o;
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s[i] == 8'h20) begin
        if (i > st) r = setf(r, s.substr(st, i - 1));
        st = i + 1;
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input vec_t exp);
    checks++;
    if (act_v !== exp) begin
      errors++;
      $display("FAIL %s: outputs got %b required %b", name, act_v, exp);
    end
    checks++;
    if ($countones({PCout, Zlowout, MDRout, Cout, BAout, Rout}) > 1) begin
      errors++;
      $display("FAIL %s bus_drivers: got %0d active drivers, required at most 1", name,
               $countones({PCout, Zlowout, MDRout, Cout, BAout, Rout}));
    end
  endtask

  // Reference model: each instruction is a list of microsteps; a step marked wt
  // stalls until mem_rdy and times out after MEM_TO stalled cycles.
  localparam int M_RST = 0, M_RUN = 1, M_HALT = 2;
  step_t prog[$];
  int    idx, wc, mode;
  bit    in_fetch, halt_after;
  logic  m_fault;

  function automatic step_t S(input string s, input logic [4:0] o = 5'd0, input logic w = 1'b0);
    step_t r;
    r.v  = E(s, o);
    r.wt = w;
    return r;
  endfunction

  task automatic load_fetch();
    prog.delete();
    prog.push_back(S("PCout MARin InPC Zlowin"));
    prog.push_back(S("Zlowout PCin Read MDRin", 5'd0, 1'b1));
    prog.push_back(S("MDRout IRin"));
    in_fetch = 1; halt_after = 0; idx = 0;
  endtask

  task automatic load_exec(input logic [4:0] o);
    prog.delete();
    in_fetch = 0; halt_after = 0; idx = 0;
    if (o < 5'd16) begin
      prog.push_back(S("Grb Rout Yin"));
      prog.push_back(S("Grc Rout ZHighin Zlowin", o));
      prog.push_back(S("Zlowout Gra Rin"));
    end else if (o == 5'd16 || o == 5'd17) begin
      prog.push_back(S("Grb BAout Yin"));
      prog.push_back(S("Cout Zlowin", 5'd3));
      prog.push_back(S("Zlowout MARin"));
      if (o == 5'd16) begin
        prog.push_back(S("Read MDRin", 5'd0, 1'b1));
        prog.push_back(S("MDRout Gra Rin"));
      end else begin
        prog.push_back(S("Gra Rout MDRin"));
        prog.push_back(S("Write", 5'd0, 1'b1));
      end
    end else if (o == 5'd18) begin
      prog.push_back(S("Grb Rout Yin"));
      prog.push_back(S("Cout Zlowin", 5'd3));
      prog.push_back(S("Zlowout Gra Rin"));
    end else if (o == 5'd19) begin
      prog.push_back(S(""));
    end else if (o == 5'd27) begin
      prog.push_back(S(""));
      halt_after = 1;
    end else begin
      prog.push_back(S("illegal"));
    end
  endtask

  task automatic model_edge(input logic clr, input logic rdy, input logic [4:0] o);
    if (!clr) begin
      mode = M_RST; m_fault = 0;
    end else if (mode == M_RST) begin
      mode = M_RUN; wc = 0; load_fetch();
    end else if (mode == M_RUN) begin
      if (prog[idx].wt && !rdy) begin
        wc++;
        if (MEM_TO > 0 && wc == MEM_TO) begin
          m_fault = 1; mode = M_HALT;
        end
      end else begin
        wc = 0; idx++;
        if (idx == prog.size()) begin
          if (in_fetch) load_exec(o);
          else if (halt_after) mode = M_HALT;
          else load_fetch();
        end
      end
    end
  endtask

  function automatic vec_t model_out();
    vec_t r = '0;
    if (mode == M_RUN) begin
      r = prog[idx].v;
      r.run = 1'b1;
    end
    r.fault = m_fault;
    return r;
  endfunction

  task automatic cyc(input logic clr, input logic rdy, input logic [4:0] o, input string name);
    clear = clr; mem_rdy = rdy; IR = {o, 27'($urandom)};
    @(posedge Clock);
    model_edge(clr, rdy, o);
    #1;
    check(name, model_out());
  endtask

  row_t tbl[$];
  task automatic row(input logic c, input logic r, input logic [4:0] o, input vec_t e);
    tbl.push_back('{clr: c, rdy: r, o: o, exp: e});
  endtask

  initial begin
    int  cnt_rd;
    bit  ld_rdy [11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
    logic c;
    mode = M_RST; m_fault = 0; idx = 0; wc = 0;

    row(0, 1, 5'd4,  E(""));
    row(1, 1, 5'd4,  E("run PCout MARin InPC Zlowin"));
    row(1, 1, 5'd4,  E("run Zlowout PCin Read MDRin"));
    row(1, 1, 5'd4,  E("run MDRout IRin"));
    row(1, 1, 5'd4,  E("run Grb Rout Yin"));
    row(1, 1, 5'd4,  E("run Grc Rout ZHighin Zlowin", 5'd4));
    row(1, 1, 5'd4,  E("run Zlowout Gra Rin"));
    row(1, 1, 5'd17, E("run PCout MARin InPC Zlowin"));
    row(1, 1, 5'd17, E("run Zlowout PCin Read MDRin"));
    row(1, 1, 5'd17, E("run MDRout IRin"));
    row(1, 1, 5'd17, E("run Grb BAout Yin"));
    row(1, 1, 5'd17, E("run Cout Zlowin", 5'd3));
    row(1, 1, 5'd17, E("run Zlowout MARin"));
    row(1, 1, 5'd17, E("run Gra Rout MDRin"));
    row(1, 1, 5'd17, E("run Write"));
    row(1, 1, 5'd31, E("run PCout MARin InPC Zlowin"));
    row(1, 1, 5'd31, E("run Zlowout PCin Read MDRin"));
    row(1, 1, 5'd31, E("run MDRout IRin"));
    row(1, 1, 5'd31, E("run illegal"));
    row(1, 1, 5'd27, E("run PCout MARin InPC Zlowin"));
    row(1, 1, 5'd27, E("run Zlowout PCin Read MDRin"));
    row(1, 1, 5'd27, E("run MDRout IRin"));
    row(1, 1, 5'd27, E("run"));
    row(1, 1, 5'd27, E(""));
    row(1, 0, 5'd27, E(""));
    row(0, 1, 5'd0,  E(""));
    row(1, 1, 5'd0,  E("run PCout MARin InPC Zlowin"));

    #2;
    foreach (tbl[i]) begin
      clear = tbl[i].clr; mem_rdy = tbl[i].rdy; IR = {tbl[i].o, 27'($urandom)};
      @(posedge Clock);
      #1;
      check($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // Asynchronous clear in the middle of an R-type T4.
    cyc(0, 1, 5'd4, "rst_a");
    for (int k = 0; k < 5; k++) cyc(1, 1, 5'd4, "rtype_to_t4");
    clear = 0;
    #1;
    check("mid_t4_clear", E(""));
    mode = M_RST; m_fault = 0;
    cyc(1, 1, 5'd4, "release");
    check("release_t0", E("run PCout MARin InPC Zlowin"));

    // ld with three stalled cycles in T6.
    cnt_rd = 0;
    for (int k = 0; k < 11; k++) begin
      cyc(1, ld_rdy[k], 5'd16, "ld");
      if (k >= 1 && Read && MDRin) cnt_rd++;
      if (k == 9) check("ld_t7", E("run MDRout Gra Rin"));
      if (k == 10) check("ld_back_t0", E("run PCout MARin InPC Zlowin"));
    end
    checks++;
    if (cnt_rd != 4) begin
      errors++;
      $display("FAIL ld_read_cycles: got %0d required 4", cnt_rd);
    end

    // Memory timeout during fetch.
    cnt_rd = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 5'd4, "timeout");
      if (Read) cnt_rd++;
      if (k >= 4) check("timeout_halt", E("fault"));
    end
    checks++;
    if (cnt_rd != 4) begin
      errors++;
      $display("FAIL timeout_wait_cycles: got %0d required 4", cnt_rd);
    end
    cyc(0, 1, 5'd0, "timeout_clear");

    for (int n = 0; n < 3000; n++) begin
      c = !((mode == M_HALT && $urandom_range(3) == 0) || $urandom_range(299) == 0);
      cyc(c, $urandom_range(3) != 0, 5'($urandom_range(31)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
